// File: rtl/core_sequencer.sv
// Multi-cycle instruction sequencer: FETCH/DECODE/EXEC/MEM/WB control strobes and retire counter.
// Optional memory-acknowledge timeout to TRAP is enabled by defining CORE_SEQ_TIMEOUT_EN.
//
// state  | meaning
// IDLE   | waiting for start
// FETCH  | instruction request outstanding
// DECODE | instruction decoded, select HALT or EXEC
// EXEC   | execute, select MEM or WB
// MEM    | data request outstanding
// WB     | write back, update PC, retire
// HALT   | system instruction seen, parked until reset
// TRAP   | memory acknowledge timed out, parked until reset
module core_sequencer #(
    parameter int XLEN           = 32,
    parameter int TIMEOUT_CYCLES = 255
) (
    input  logic            clk,
    input  logic            rst,
    input  logic            start,
    input  logic            imem_ack,
    input  logic            dmem_ack,
    input  logic            mem_read,
    input  logic            mem_write,
    input  logic            reg_write,
    input  logic            is_branch,
    input  logic            is_system,
    input  logic            branch_taken,
    output logic            imem_req,
    output logic            ir_write,
    output logic            dmem_req,
    output logic            dmem_we,
    output logic            rf_we,
    output logic            pc_write,
    output logic            pc_sel,
    output logic            busy,
    output logic            err,
    output logic [2:0]      state,
    output logic [XLEN-1:0] retired_count
);

    typedef enum logic [2:0] {
        S_IDLE   = 3'd0,
        S_FETCH  = 3'd1,
        S_DECODE = 3'd2,
        S_EXEC   = 3'd3,
        S_MEM    = 3'd4,
        S_WB     = 3'd5,
        S_HALT   = 3'd6,
        S_TRAP   = 3'd7
    } state_t;

    state_t          r_state;
    state_t          w_next;
    logic [XLEN-1:0] r_retired;
    logic            w_timeout;

`ifdef CORE_SEQ_TIMEOUT_EN
    localparam int CW = $clog2(TIMEOUT_CYCLES + 1);

    logic [CW-1:0] r_wait_cnt;
    logic          r_err;
    logic          w_wait;

    assign w_wait    = ((r_state == S_FETCH) && !imem_ack) || ((r_state == S_MEM) && !dmem_ack);
    assign w_timeout = w_wait && (r_wait_cnt == CW'(TIMEOUT_CYCLES - 1));

    // Counter restarts on every state change, so each FETCH/MEM visit gets a full budget.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_wait_cnt <= '0;
            r_err      <= 1'b0;
        end else begin
            if (w_next != r_state) begin
                r_wait_cnt <= '0;
            end else if (w_wait) begin
                r_wait_cnt <= r_wait_cnt + CW'(1);
            end
            if (w_next == S_TRAP) begin
                r_err <= 1'b1;
            end
        end
    end

    assign err = r_err;
`else
    assign w_timeout = 1'b0;
    assign err       = 1'b0;
`endif

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_state   <= S_IDLE;
            r_retired <= '0;
        end else begin
            r_state <= w_next;
            if (r_state == S_WB) begin
                r_retired <= r_retired + XLEN'(1);
            end
        end
    end

    always_comb begin
        w_next   = r_state;
        imem_req = 1'b0;
        ir_write = 1'b0;
        dmem_req = 1'b0;
        dmem_we  = 1'b0;
        rf_we    = 1'b0;
        pc_write = 1'b0;
        pc_sel   = 1'b0;
        busy     = 1'b0;
        case (r_state)
            S_IDLE: begin
                if (start) begin
                    w_next = S_FETCH;
                end
            end
            S_FETCH: begin
                busy     = 1'b1;
                imem_req = 1'b1;
                ir_write = imem_ack;
                if (imem_ack) begin
                    w_next = S_DECODE;
                end else if (w_timeout) begin
                    w_next = S_TRAP;
                end
            end
            S_DECODE: begin
                busy   = 1'b1;
                w_next = is_system ? S_HALT : S_EXEC;
            end
            S_EXEC: begin
                busy   = 1'b1;
                w_next = (mem_read || mem_write) ? S_MEM : S_WB;
            end
            S_MEM: begin
                busy     = 1'b1;
                dmem_req = 1'b1;
                dmem_we  = mem_write;
                if (dmem_ack) begin
                    w_next = S_WB;
                end else if (w_timeout) begin
                    w_next = S_TRAP;
                end
            end
            S_WB: begin
                busy     = 1'b1;
                rf_we    = reg_write & ~mem_write;
                pc_write = 1'b1;
                pc_sel   = is_branch & branch_taken;
                w_next   = S_FETCH;
            end
            S_HALT:  w_next = S_HALT;
            S_TRAP:  w_next = S_TRAP;
            default: w_next = S_IDLE;
        endcase
    end

    assign state         = r_state;
    assign retired_count = r_retired;

endmodule

// File: tb/tb_core_sequencer.sv
// Self-checking bench for core_sequencer (XLEN=8, TIMEOUT_CYCLES=4); per-instruction expectations
// are queued when the instruction is issued and checked when the sequencer reaches WB.
module tb_core_sequencer;

    localparam int XLEN           = 8;
    localparam int TIMEOUT_CYCLES = 4;

    logic            clk;
    logic            rst;
    logic            start;
    logic            imem_ack;
    logic            dmem_ack;
    logic            mem_read;
    logic            mem_write;
    logic            reg_write;
    logic            is_branch;
    logic            is_system;
    logic            branch_taken;
    logic            imem_req;
    logic            ir_write;
    logic            dmem_req;
    logic            dmem_we;
    logic            rf_we;
    logic            pc_write;
    logic            pc_sel;
    logic            busy;
    logic            err;
    logic [2:0]      state;
    logic [XLEN-1:0] retired_count;

    typedef struct packed {
        logic            rf_we;
        logic            pc_sel;
        logic [XLEN-1:0] cnt;
    } exp_t;

    exp_t            sb[$];
    logic [XLEN-1:0] model_cnt;
    int              checks;
    int              errors;

    core_sequencer #(
        .XLEN(XLEN),
        .TIMEOUT_CYCLES(TIMEOUT_CYCLES)
    ) dut (
        .clk(clk),
        .rst(rst),
        .start(start),
        .imem_ack(imem_ack),
        .dmem_ack(dmem_ack),
        .mem_read(mem_read),
        .mem_write(mem_write),
        .reg_write(reg_write),
        .is_branch(is_branch),
        .is_system(is_system),
        .branch_taken(branch_taken),
        .imem_req(imem_req),
        .ir_write(ir_write),
        .dmem_req(dmem_req),
        .dmem_we(dmem_we),
        .rf_we(rf_we),
        .pc_write(pc_write),
        .pc_sel(pc_sel),
        .busy(busy),
        .err(err),
        .state(state),
        .retired_count(retired_count)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #1000000;
        $display("FAIL watchdog time limit reached, checks=%0d", checks);
        $fatal(1, "watchdog");
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic apply_reset();
        start = 1'b0; imem_ack = 1'b0; dmem_ack = 1'b0;
        rst = 1'b0;
        #3;
        rst = 1'b1;
        model_cnt = '0;
        sb.delete();
        tick();
    endtask

    task automatic do_start();
        start = 1'b1;
        tick();
        start = 1'b0;
    endtask

    // Runs one instruction from the first FETCH cycle; ends in the next FETCH (or in HALT).
    task automatic run_instr(input logic mr, input logic mw, input logic rw, input logic br,
                             input logic bt, input logic sys, input int idly, input int ddly);
        exp_t e;
        mem_read = mr; mem_write = mw; reg_write = rw;
        is_branch = br; branch_taken = bt; is_system = sys;
        if (!sys) begin
            model_cnt++;
            e.rf_we  = rw & ~mw;
            e.pc_sel = br & bt;
            e.cnt    = model_cnt;
            sb.push_back(e);
        end
        for (int i = 0; i < idly; i++) begin
            imem_ack = 1'b0; dmem_ack = 1'b1;
            #1;
            checks++;
            if (state !== 3'd1 || imem_req !== 1'b1 || ir_write !== 1'b0 || dmem_req !== 1'b0) begin
                errors++;
                $display("FAIL fetch_wait state=%0d imem_req=%b ir_write=%b dmem_req=%b want 1 1 0 0",
                         state, imem_req, ir_write, dmem_req);
            end
            tick();
        end
        dmem_ack = 1'b0; imem_ack = 1'b1;
        #1;
        checks++;
        if (state !== 3'd1 || imem_req !== 1'b1 || ir_write !== 1'b1 || busy !== 1'b1) begin
            errors++;
            $display("FAIL fetch_ack state=%0d imem_req=%b ir_write=%b busy=%b want 1 1 1 1",
                     state, imem_req, ir_write, busy);
        end
        tick();
        imem_ack = 1'b0;
        checks++;
        if (state !== 3'd2 || busy !== 1'b1 || imem_req !== 1'b0) begin
            errors++;
            $display("FAIL decode state=%0d busy=%b imem_req=%b want 2 1 0", state, busy, imem_req);
        end
        tick();
        if (sys) begin
            checks++;
            if (state !== 3'd6 || busy !== 1'b0 || pc_write !== 1'b0) begin
                errors++;
                $display("FAIL halt state=%0d busy=%b pc_write=%b want 6 0 0", state, busy, pc_write);
            end
            return;
        end
        checks++;
        if (state !== 3'd3 || busy !== 1'b1) begin
            errors++;
            $display("FAIL exec state=%0d busy=%b want 3 1", state, busy);
        end
        tick();
        if (mr || mw) begin
            for (int i = 0; i <= ddly; i++) begin
                dmem_ack = (i == ddly);
                imem_ack = (i != ddly);
                #1;
                checks++;
                if (state !== 3'd4 || dmem_req !== 1'b1 || dmem_we !== mw || ir_write !== 1'b0) begin
                    errors++;
                    $display("FAIL mem_cycle%0d state=%0d dmem_req=%b dmem_we=%b ir_write=%b want 4 1 %b 0",
                             i, state, dmem_req, dmem_we, ir_write, mw);
                end
                tick();
            end
            dmem_ack = 1'b0; imem_ack = 1'b0;
        end
        #1;
        e = sb.pop_front();
        checks++;
        if (state !== 3'd5 || rf_we !== e.rf_we || pc_sel !== e.pc_sel || pc_write !== 1'b1 || dmem_req !== 1'b0) begin
            errors++;
            $display("FAIL wb state=%0d rf_we=%b pc_sel=%b pc_write=%b dmem_req=%b want 5 %b %b 1 0",
                     state, rf_we, pc_sel, pc_write, dmem_req, e.rf_we, e.pc_sel);
        end
        tick();
        checks++;
        if (state !== 3'd1 || retired_count !== e.cnt) begin
            errors++;
            $display("FAIL retire state=%0d retired_count=%0d want 1 %0d", state, retired_count, e.cnt);
        end
    endtask

    task automatic test_reset();
        rst = 1'b0;
        #2;
        checks++;
        if (state !== 3'd0 || retired_count !== '0 || err !== 1'b0 || busy !== 1'b0 || imem_req !== 1'b0) begin
            errors++;
            $display("FAIL reset state=%0d retired=%0d err=%b busy=%b imem_req=%b want all 0",
                     state, retired_count, err, busy, imem_req);
        end
        apply_reset();
        tick();
        checks++;
        if (state !== 3'd0 || imem_req !== 1'b0) begin
            errors++;
            $display("FAIL idle_hold state=%0d imem_req=%b want 0 0", state, imem_req);
        end
    endtask

    task automatic test_alu();
        do_start();
        run_instr(1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 0, 0);
        run_instr(1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 2, 0);
    endtask

    task automatic test_load_store();
        run_instr(1'b1, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 0, 3);
        run_instr(1'b0, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 1, 3);
        run_instr(1'b1, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 0, 0);
    endtask

    task automatic test_branch();
        run_instr(1'b0, 1'b0, 1'b0, 1'b1, 1'b1, 1'b0, 0, 0);
        run_instr(1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 0, 0);
        run_instr(1'b0, 1'b0, 1'b1, 1'b0, 1'b1, 1'b0, 0, 0);
    endtask

    task automatic test_system();
        run_instr(1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 0, 0);
        is_system = 1'b0;
        for (int i = 0; i < 3; i++) begin
            start = (i != 1);
            tick();
        end
        start = 1'b0;
        checks++;
        if (state !== 3'd6 || busy !== 1'b0 || retired_count !== model_cnt || imem_req !== 1'b0) begin
            errors++;
            $display("FAIL halt_hold state=%0d busy=%b retired=%0d imem_req=%b want 6 0 %0d 0",
                     state, busy, retired_count, imem_req, model_cnt);
        end
    endtask

    task automatic test_wrap();
        apply_reset();
        do_start();
        while (model_cnt != {XLEN{1'b1}}) begin
            run_instr(1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 0, 0);
        end
        run_instr(1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 0, 0);
        checks++;
        if (retired_count !== '0 || err !== 1'b0) begin
            errors++;
            $display("FAIL wrap retired=%0d err=%b want 0 0", retired_count, err);
        end
    endtask

    task automatic test_reset_mid_mem();
        apply_reset();
        do_start();
        mem_read = 1'b1; mem_write = 1'b0; is_system = 1'b0;
        imem_ack = 1'b1;
        tick();
        imem_ack = 1'b0;
        tick();
        tick();
        #1;
        checks++;
        if (state !== 3'd4 || dmem_req !== 1'b1) begin
            errors++;
            $display("FAIL pre_reset_mem state=%0d dmem_req=%b want 4 1", state, dmem_req);
        end
        rst = 1'b0;
        #1;
        checks++;
        if (state !== 3'd0 || dmem_req !== 1'b0 || busy !== 1'b0 || retired_count !== '0) begin
            errors++;
            $display("FAIL async_reset state=%0d dmem_req=%b busy=%b retired=%0d want 0 0 0 0",
                     state, dmem_req, busy, retired_count);
        end
        #1;
        rst = 1'b1;
        dmem_ack = 1'b1; imem_ack = 1'b1;
        tick();
        tick();
        checks++;
        if (state !== 3'd0 || imem_req !== 1'b0 || rf_we !== 1'b0 || retired_count !== '0) begin
            errors++;
            $display("FAIL stale_ack state=%0d imem_req=%b rf_we=%b retired=%0d want 0 0 0 0",
                     state, imem_req, rf_we, retired_count);
        end
        dmem_ack = 1'b0; imem_ack = 1'b0; mem_read = 1'b0;
    endtask

    task automatic test_timeout();
        logic [2:0] exp_state;
        logic       exp_err;
        logic       exp_req;
        apply_reset();
        do_start();
        for (int i = 0; i < TIMEOUT_CYCLES - 1; i++) tick();
        checks++;
        if (state !== 3'd1 || err !== 1'b0 || imem_req !== 1'b1) begin
            errors++;
            $display("FAIL timeout_pre state=%0d err=%b imem_req=%b want 1 0 1", state, err, imem_req);
        end
`ifdef CORE_SEQ_TIMEOUT_EN
        exp_state = 3'd7; exp_err = 1'b1; exp_req = 1'b0;
`else
        exp_state = 3'd1; exp_err = 1'b0; exp_req = 1'b1;
`endif
        for (int i = 0; i < 3; i++) begin
            tick();
            checks++;
            if (state !== exp_state || err !== exp_err || imem_req !== exp_req || busy !== exp_req) begin
                errors++;
                $display("FAIL timeout_%0d state=%0d err=%b imem_req=%b busy=%b want %0d %b %b %b",
                         i, state, err, imem_req, busy, exp_state, exp_err, exp_req, exp_req);
            end
        end
    endtask

    initial begin
        checks = 0; errors = 0; model_cnt = '0;
        rst = 1'b1; start = 1'b0; imem_ack = 1'b0; dmem_ack = 1'b0;
        mem_read = 1'b0; mem_write = 1'b0; reg_write = 1'b0;
        is_branch = 1'b0; is_system = 1'b0; branch_taken = 1'b0;
        #2;
        test_reset();
        test_alu();
        test_load_store();
        test_branch();
        test_system();
        test_wrap();
        test_reset_mid_mem();
        test_timeout();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/core_sequencer.md
CORE_SEQUENCER -- requirements
Module: core_sequencer

Interface
REQ-001 SHALL have parameter XLEN, default 32, datapath width of the retire counter.
REQ-002 SHALL have parameter TIMEOUT_CYCLES, default 255, the wait limit for a memory acknowledge (used only under CORE_SEQ_TIMEOUT_EN).
REQ-003 SHALL have the following ports (name  direction  width  meaning):
- clk  in  1  single clock; all state changes on rising edge.
- rst  in  1  asynchronous, active-low reset.
- start  in  1  leave IDLE; sampled in IDLE only.
- imem_ack  in  1  instruction memory acknowledge.
- dmem_ack  in  1  data memory acknowledge.
- mem_read  in  1  decoded instruction is a load.
- mem_write  in  1  decoded instruction is a store.
- reg_write  in  1  decoded instruction writes rd.
- is_branch  in  1  decoded instruction is a conditional branch.
- is_system  in  1  decoded opcode is 1110011.
- branch_taken  in  1  branch condition result from execute.
- imem_req  out  1  instruction fetch request.
- ir_write  out  1  latch instruction register.
- dmem_req  out  1  data memory request.
- dmem_we  out  1  data request is a write.
- rf_we  out  1  register file write enable.
- pc_write  out  1  update PC.
- pc_sel  out  1  1 = branch target, 0 = PC+4.
- busy  out  1  sequencer is executing.
- err  out  1  sticky memory-timeout flag.
- state  out  3  current state encoding.
- retired_count  out  XLEN  instructions retired.

Function
REQ-004 SHALL encode states IDLE=0, FETCH=1, DECODE=2, EXEC=3, MEM=4, WB=5, HALT=6, TRAP=7.
REQ-005 IDLE: outputs 0; start=1 -> FETCH next edge; else stay.
REQ-006 FETCH: imem_req=1 every cycle in state; imem_ack=1 -> ir_write=1 same cycle (combinational), -> DECODE; else stay.
REQ-007 Ack in the first FETCH/MEM cycle SHALL be accepted (minimum one cycle in the state).
REQ-008 DECODE: one cycle; is_system=1 -> HALT, else -> EXEC.
REQ-009 EXEC: one cycle; mem_read|mem_write -> MEM, else -> WB.
REQ-010 MEM: dmem_req=1, dmem_we=mem_write, held each cycle in state; dmem_ack=1 -> WB; else stay.
REQ-011 WB: one cycle; rf_we=reg_write&~mem_write; pc_write=1; pc_sel=is_branch&branch_taken; retired_count increments; -> FETCH.
REQ-012 retired_count SHALL wrap from 2^XLEN-1 to 0 without flag.
REQ-013 HALT: all strobes 0, busy=0; start ignored; exit only by reset; system instruction not counted as retired.
REQ-014 busy SHALL be 1 in FETCH, DECODE, EXEC, MEM, WB; 0 otherwise.
REQ-015 imem_ack outside FETCH and dmem_ack outside MEM SHALL be ignored.
REQ-016 Latency: non-memory instruction 4 cycles minimum, load/store 5 cycles minimum, start to first imem_req 1 cycle.

Reset
REQ-017 rst=0 SHALL immediately force state=IDLE, retired_count=0, err=0, all other outputs 0, independent of clk.
REQ-018 Reset mid-FETCH/MEM SHALL drop the request same cycle; no later ack is honoured until a new FETCH.

Configuration
REQ-019 Macro CORE_SEQ_TIMEOUT_EN defined: a wait counter clears on entry to FETCH/MEM, counts each cycle without ack; reaching TIMEOUT_CYCLES -> TRAP, err=1, all requests 0; TRAP exits only by reset.
REQ-020 Macro undefined: no counter, FETCH/MEM wait indefinitely, err tied 0, TRAP unreachable.

Verification
REQ-021 Reset, start=1, imem_ack=1 immediately, non-memory ALU op with reg_write=1 -> states 1,2,3,5,1; rf_we=1 and pc_write=1 in WB; retired_count=1.
REQ-022 Load, dmem_ack delayed 3 cycles -> dmem_req=1, dmem_we=0 for exactly 4 MEM cycles, then WB with rf_we=1; store same -> dmem_we=1, rf_we=0.
REQ-023 Branch with branch_taken=1 -> pc_sel=1 in WB; with 0 -> pc_sel=0; rf_we=0 for reg_write=0.
REQ-024 is_system=1 in DECODE -> state=6, busy=0, retired_count unchanged, start pulses ignored.
REQ-025 retired_count preset near max (XLEN=8, 255) plus one retire -> 0; rst=0 asserted mid-MEM -> state=0, dmem_req=0 before next edge.
REQ-026 With CORE_SEQ_TIMEOUT_EN, TIMEOUT_CYCLES=4, imem_ack held 0 -> state=7 and err=1 after 4 FETCH cycles; without macro -> remains FETCH, err=0.
